// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus between the OTTER core and hazard_ctrl.
// The core side (master) supplies register/stage information and memory
// handshake status; the controller side (slave) returns enables, flushes
// and the data-memory request.
interface hazard_ctrl_if;
    logic [4:0] if_id_rs1;
    logic [4:0] if_id_rs2;
    logic       if_id_uses_rs1;
    logic       if_id_uses_rs2;
    logic       if_id_is_branch;
    logic       branch_taken;
    logic [4:0] id_ex_rd;
    logic       id_ex_regWrite;
    logic       id_ex_memRead;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_memRead;
    logic       ex_mem_access;
    logic       dmem_ack;
    logic       imem_ready;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;
    logic       dmem_req;

    modport master (
        output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
               if_id_is_branch, branch_taken, id_ex_rd, id_ex_regWrite,
               id_ex_memRead, ex_mem_rd, ex_mem_memRead, ex_mem_access,
               dmem_ack, imem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, dmem_req
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
               if_id_is_branch, branch_taken, id_ex_rd, id_ex_regWrite,
               id_ex_memRead, ex_mem_rd, ex_mem_memRead, ex_mem_access,
               dmem_ack, imem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, dmem_req
    );
endinterface

// File: rtl/hazard_ctrl.sv
// OTTER pipeline sequencing controller: stalls/flushes for load-use and
// decode-branch operand hazards, branch redirects, fetch misses and
// data-memory waits, plus stall/flush counters and a sticky timeout flag.
module hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    hazard_ctrl_if.slave      bus,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              err_dmem_timeout
);
    localparam logic [0:0] RUN       = 1'b0;
    localparam logic [0:0] DMEM_WAIT = 1'b1;
    // wait_cnt never exceeds DMEM_TIMEOUT-1
    localparam int WC_W = $clog2(DMEM_TIMEOUT);

    logic [0:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             err_q, err_d;

    logic load_use, br_ex, br_mem, hz;
    logic req, at_limit, dmem_hold, forced_rel, redirect;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush;

    // Decode operand depends on a producer register (x0 never matches)
    function automatic logic src_match(input logic uses, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return uses && (rs == rd) && (rd != 5'd0);
    endfunction

    // Hazard detection and memory handshake status
    always_comb begin
        load_use = bus.id_ex_memRead &&
                   (src_match(bus.if_id_uses_rs1, bus.if_id_rs1, bus.id_ex_rd) ||
                    src_match(bus.if_id_uses_rs2, bus.if_id_rs2, bus.id_ex_rd));
        br_ex    = bus.if_id_is_branch && bus.id_ex_regWrite &&
                   (src_match(bus.if_id_uses_rs1, bus.if_id_rs1, bus.id_ex_rd) ||
                    src_match(bus.if_id_uses_rs2, bus.if_id_rs2, bus.id_ex_rd));
        br_mem   = bus.if_id_is_branch && bus.ex_mem_memRead &&
                   (src_match(bus.if_id_uses_rs1, bus.if_id_rs1, bus.ex_mem_rd) ||
                    src_match(bus.if_id_uses_rs2, bus.if_id_rs2, bus.ex_mem_rd));
        hz       = load_use || br_ex || br_mem;

        // Request is suppressed in reset so an in-flight access is aborted
        req        = !RST && (((state_q == RUN) && bus.ex_mem_access) ||
                              (state_q == DMEM_WAIT));
        at_limit   = (wait_cnt_q == WC_W'(DMEM_TIMEOUT - 1));
        dmem_hold  = req && !bus.dmem_ack && !at_limit;
        forced_rel = req && !bus.dmem_ack && at_limit;
        redirect   = !RST && !dmem_hold && !hz && bus.branch_taken;
    end

    // Prioritised enable/flush generation
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (RST) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (dmem_hold) begin
            // Freeze everything up to MEM; WB drains and receives a bubble
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (hz) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.branch_taken) begin
            // Redirect wins over a missing fetch: the fetched word is discarded anyway
            if_id_flush = 1'b1;
        end else if (!bus.imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    // Next-state for FSM, wait counter, performance counters and error flag
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        stall_d    = stall_q;
        flush_d    = flush_q;
        err_d      = err_q;
        if (dmem_hold) begin
            state_d    = DMEM_WAIT;
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        end else if (state_q == DMEM_WAIT) begin
            state_d = RUN;
        end
        if (!pc_en)     stall_d = stall_q + CNT_W'(1);
        if (redirect)   flush_d = flush_q + CNT_W'(1);
        if (forced_rel) err_d   = 1'b1;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.mem_wb_en    = mem_wb_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.dmem_req     = req;

    assign stall_cycles     = stall_q;
    assign flush_count      = flush_q;
    assign err_dmem_timeout = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (DMEM_TIMEOUT=4).
module tb_hazard_ctrl;
    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, isbr, bt;
        logic [4:0] idrd;
        logic       idrw, idmr;
        logic [4:0] exrd;
        logic       exmr, exacc, ack, imrdy;
    } vec_t;

    typedef struct {
        string      nm;
        vec_t       v;
        logic [8:0] exp;
    } tv_t;

    typedef struct {
        string      nm;
        logic [8:0] exp;
    } sb_t;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes, dmem_req}
    localparam logic [8:0] NORM   = 9'b11111_000_0;
    localparam logic [8:0] NORM_R = 9'b11111_000_1;
    localparam logic [8:0] RSTV   = 9'b00000_111_0;
    localparam logic [8:0] HOLD   = 9'b00001_001_1;
    localparam logic [8:0] HZ     = 9'b00111_010_0;
    localparam logic [8:0] HZ_R   = 9'b00111_010_1;
    localparam logic [8:0] BR     = 9'b11111_100_0;
    localparam logic [8:0] NOIM   = 9'b01111_100_0;

    logic        CLK;
    logic        RST;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic        err_dmem_timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic        m_err   = 1'b0;

    sb_t sbq[$];
    tv_t tbl[$];

    hazard_ctrl_if bus();

    hazard_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(32)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .bus              (bus),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count),
        .err_dmem_timeout (err_dmem_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic isbr, input logic bt,
                                input logic [4:0] idrd, input logic idrw,
                                input logic idmr, input logic [4:0] exrd,
                                input logic exmr, input logic exacc,
                                input logic ack, input logic imrdy);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.isbr = isbr; v.bt = bt; v.idrd = idrd; v.idrw = idrw; v.idmr = idmr;
        v.exrd = exrd; v.exmr = exmr; v.exacc = exacc; v.ack = ack; v.imrdy = imrdy;
        return v;
    endfunction

    task automatic add(input string nm, input vec_t v, input logic [8:0] e);
        tv_t t;
        t.nm = nm; t.v = v; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic step(input string nm, input vec_t v, input logic r,
                        input logic [8:0] e, input bit forced);
        sb_t s;
        sb_t got;
        logic [8:0] act;
        @(posedge CLK);
        #1;
        bus.if_id_rs1       = v.rs1;
        bus.if_id_rs2       = v.rs2;
        bus.if_id_uses_rs1  = v.u1;
        bus.if_id_uses_rs2  = v.u2;
        bus.if_id_is_branch = v.isbr;
        bus.branch_taken    = v.bt;
        bus.id_ex_rd        = v.idrd;
        bus.id_ex_regWrite  = v.idrw;
        bus.id_ex_memRead   = v.idmr;
        bus.ex_mem_rd       = v.exrd;
        bus.ex_mem_memRead  = v.exmr;
        bus.ex_mem_access   = v.exacc;
        bus.dmem_ack        = v.ack;
        bus.imem_ready      = v.imrdy;
        RST                 = r;
        s.nm = nm; s.exp = e;
        sbq.push_back(s);
        @(negedge CLK);
        got = sbq.pop_front();
        act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
               bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.dmem_req};
        checks++;
        if (act !== got.exp) begin
            errors++;
            $display("FAIL %s outputs: got %b, expected %b", got.nm, act, got.exp);
        end
        chk({got.nm, " stall_cycles"}, stall_cycles, m_stall);
        chk({got.nm, " flush_count"}, flush_count, m_flush);
        chk({got.nm, " err_dmem_timeout"}, {31'd0, err_dmem_timeout}, {31'd0, m_err});
        if (r) begin
            m_stall = '0;
            m_flush = '0;
            m_err   = 1'b0;
        end else begin
            if (!e[8])        m_stall = m_stall + 32'd1;
            if (e[8] && e[3]) m_flush = m_flush + 32'd1;
            if (forced)       m_err   = 1'b1;
        end
    endtask

    vec_t idle, acc, acc_ack, acc_lu, acc_ack_lu;

    initial begin
        RST = 1'b1;
        idle       = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,1);
        acc        = mk(0,0,0,0,0,0, 0,0,0, 0,0,1,0,1);
        acc_ack    = mk(0,0,0,0,0,0, 0,0,0, 0,0,1,1,1);
        acc_lu     = mk(5,0,1,0,0,0, 5,1,1, 0,0,1,0,1);
        acc_ack_lu = mk(5,0,1,0,0,0, 5,1,1, 0,0,1,1,1);

        add("idle",            idle,                                  NORM);
        add("load_use_rs1",    mk(5,1,1,1,0,0, 5,1,1, 0,0,0,0,1),     HZ);
        add("load_use_x0",     mk(0,0,1,1,0,0, 0,1,1, 0,0,0,0,1),     NORM);
        add("load_use_unused", mk(5,0,0,0,0,0, 5,1,1, 0,0,0,0,1),     NORM);
        add("load_use_rs2",    mk(1,9,1,1,0,0, 9,1,1, 0,0,0,0,1),     HZ);
        add("alu_then_branch", mk(3,0,1,0,1,0, 3,1,0, 0,0,0,0,1),     HZ);
        add("alu_then_alu",    mk(3,0,1,0,0,0, 3,1,0, 0,0,0,0,1),     NORM);
        add("br_mem",          mk(0,8,0,1,1,0, 0,0,0, 8,1,0,0,1),     HZ);
        add("branch_taken",    mk(1,2,1,1,1,1, 4,1,0, 6,1,0,0,1),     BR);
        add("bt_imem_not_rdy", mk(0,0,0,0,1,1, 0,0,0, 0,0,0,0,0),     BR);
        add("imem_not_rdy",    mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0),     NOIM);
        add("hz_over_branch",  mk(5,0,1,0,1,1, 5,1,1, 0,0,0,0,1),     HZ);
        add("zero_wait_acc",   acc_ack,                               NORM_R);
        add("hz_with_acc_ack", acc_ack_lu,                            HZ_R);

        step("reset0", idle, 1'b1, RSTV, 1'b0);
        step("reset1", idle, 1'b1, RSTV, 1'b0);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].nm, tbl[i].v, 1'b0, tbl[i].exp, 1'b0);

        // lw x7 ; beq x7,x0 : br_ex then br_mem, then taken redirect
        step("lb_c1", mk(7,0,1,1,1,0, 7,1,1, 0,0,0,0,1), 1'b0, HZ,   1'b0);
        step("lb_c2", mk(7,0,1,1,1,0, 0,0,0, 7,1,1,1,1), 1'b0, HZ_R, 1'b0);
        step("lb_c3", mk(7,0,1,1,1,1, 0,0,0, 0,0,0,0,1), 1'b0, BR,   1'b0);
        step("lb_c4", idle,                              1'b0, NORM, 1'b0);

        // ack on 3rd request cycle, load-use pending during the wait
        step("ack3_c1", acc,        1'b0, HOLD, 1'b0);
        step("ack3_c2", acc_lu,     1'b0, HOLD, 1'b0);
        step("ack3_c3", acc_ack_lu, 1'b0, HZ_R, 1'b0);
        step("ack3_c4", idle,       1'b0, NORM, 1'b0);

        // no ack: forced release on 4th request cycle
        step("to_c1", acc,  1'b0, HOLD,   1'b0);
        step("to_c2", acc,  1'b0, HOLD,   1'b0);
        step("to_c3", acc,  1'b0, HOLD,   1'b0);
        step("to_c4", acc,  1'b0, NORM_R, 1'b1);
        step("to_c5", idle, 1'b0, NORM,   1'b0);
        step("to_c6", idle, 1'b0, NORM,   1'b0);

        // reset during the second DMEM_WAIT cycle
        step("rst_c1", acc,  1'b0, HOLD, 1'b0);
        step("rst_c2", acc,  1'b0, HOLD, 1'b0);
        step("rst_c3", acc,  1'b1, RSTV, 1'b0);
        step("rst_c4", idle, 1'b0, NORM, 1'b0);
        step("rst_c5", acc_ack, 1'b0, NORM_R, 1'b0);
        step("rst_c6", idle, 1'b0, NORM, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
